// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic-array buffer blocks: default
// dimensions, the buffer sequencing states and width helpers.
package systolic_pkg;

  localparam int unsigned SIZE_DEFAULT         = 8;
  localparam int unsigned WEIGHT_WIDTH_DEFAULT = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READY  = 2'd1,
    STREAM = 2'd2
  } state_t;

  // Width of a linear row*SIZE+col address
  function automatic int unsigned addr_width(input int unsigned size);
    return $clog2(size * size);
  endfunction

  // Width of a row (or column) index
  function automatic int unsigned row_width(input int unsigned size);
    return $clog2(size);
  endfunction

  function automatic bit is_pow2(input int unsigned n);
    return (n != 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/weight_row_bank.sv
// Row-organised weight storage: SIZE row registers, one weight written
// per cycle at (row, col), whole-row combinational read.
module weight_row_bank
  import systolic_pkg::*;
#(
  parameter int unsigned SIZE         = SIZE_DEFAULT,
  parameter int unsigned WEIGHT_WIDTH = WEIGHT_WIDTH_DEFAULT,
  parameter int unsigned ROW_WIDTH    = row_width(SIZE)
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [ROW_WIDTH-1:0]         wr_row,
  input  logic [ROW_WIDTH-1:0]         wr_col,
  input  logic [WEIGHT_WIDTH-1:0]      wr_data,
  input  logic [ROW_WIDTH-1:0]         rd_row,
  output logic [SIZE*WEIGHT_WIDTH-1:0] rd_data
);

  logic [SIZE*WEIGHT_WIDTH-1:0] rows [SIZE];

  // Single-weight write into the addressed row; contents survive reset
  always_ff @(posedge clk) begin
    if (we) begin
      rows[wr_row][wr_col*WEIGHT_WIDTH +: WEIGHT_WIDTH] <= wr_data;
    end
  end

  assign rd_data = rows[rd_row];

endmodule

// File: rtl/weight_preload_buffer.sv
// Weight store for a SIZE x SIZE weight-stationary array: loaded one
// weight per cycle, streamed one row per cycle (bottom row first).
module weight_preload_buffer
  import systolic_pkg::*;
#(
  parameter int unsigned SIZE         = SIZE_DEFAULT,
  parameter int unsigned WEIGHT_WIDTH = WEIGHT_WIDTH_DEFAULT,
  parameter int unsigned ADDR_WIDTH   = addr_width(SIZE),
  parameter int unsigned ROW_WIDTH    = row_width(SIZE)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [WEIGHT_WIDTH-1:0]      wr_data,
  input  logic                         load_done,
  input  logic                         start,
  output logic                         row_valid,
  output logic [SIZE*WEIGHT_WIDTH-1:0] row_data,
  output logic [ROW_WIDTH-1:0]         row_idx,
  output logic                         ready,
  output logic                         busy,
  output logic                         stream_done,
  output logic                         wr_err
);

  localparam int unsigned DEPTH = SIZE * SIZE;

  if (!is_pow2(SIZE) || SIZE < 2 || SIZE > 32) begin : g_bad_size
    $error("weight_preload_buffer: SIZE must be a power of two in 2..32");
  end
  if (ADDR_WIDTH < 2 * ROW_WIDTH) begin : g_bad_addr_width
    $error("weight_preload_buffer: ADDR_WIDTH too narrow for SIZE*SIZE");
  end

  state_t                       state;
  logic [ROW_WIDTH-1:0]         cnt;
  logic                         addr_ok;
  logic                         wr_accept;
  logic                         wr_drop;
  logic [ROW_WIDTH-1:0]         wr_row;
  logic [ROW_WIDTH-1:0]         wr_col;
  logic [SIZE*WEIGHT_WIDTH-1:0] rd_data;

  // SIZE is a power of two, so row/col are plain bit fields of the address
  assign wr_col  = wr_addr[ROW_WIDTH-1:0];
  assign wr_row  = wr_addr[2*ROW_WIDTH-1:ROW_WIDTH];
  assign addr_ok = (32'(wr_addr) < DEPTH);

  // A start in READY takes priority over a same-cycle write
  always_comb begin
    wr_accept = 1'b0;
    wr_drop   = 1'b0;
    if (wr_en) begin
      wr_accept = addr_ok && ((state == IDLE) || (state == READY && !start));
      wr_drop   = !wr_accept;
    end
  end

  weight_row_bank #(
    .SIZE         (SIZE),
    .WEIGHT_WIDTH (WEIGHT_WIDTH),
    .ROW_WIDTH    (ROW_WIDTH)
  ) u_bank (
    .clk     (clk),
    .we      (wr_accept),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_data (wr_data),
    .rd_row  (cnt),
    .rd_data (rd_data)
  );

  // Sequencer, row counter and registered outputs; outputs trail the
  // state by one cycle, and stream_done follows the row-0 output cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      row_valid   <= 1'b0;
      row_data    <= '0;
      row_idx     <= '0;
      ready       <= 1'b0;
      busy        <= 1'b0;
      stream_done <= 1'b0;
      wr_err      <= 1'b0;
    end else begin
      row_valid   <= (state == STREAM);
      busy        <= (state == STREAM);
      row_data    <= (state == STREAM) ? rd_data : '0;
      row_idx     <= (state == STREAM) ? cnt : '0;
      ready       <= (state == READY);
      stream_done <= row_valid && (row_idx == '0);
      wr_err      <= wr_drop;
      case (state)
        IDLE: begin
          if (load_done) state <= READY;
        end
        READY: begin
          if (start) begin
            state <= STREAM;
            cnt   <= ROW_WIDTH'(SIZE - 1);
          end
        end
        STREAM: begin
          if (cnt == '0) state <= READY;
          else           cnt   <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_preload_buffer.sv
// Bench for weight_preload_buffer: an 8x8x5-bit instance (with a wide
// address port to reach out-of-range addresses) and a 4x4x8-bit instance.
module tb_weight_preload_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a_wr_en, a_load_done, a_start;
  logic [6:0]  a_wr_addr;
  logic [4:0]  a_wr_data;
  logic        a_row_valid, a_ready, a_busy, a_stream_done, a_wr_err;
  logic [39:0] a_row_data;
  logic [2:0]  a_row_idx;

  logic        b_wr_en, b_load_done, b_start;
  logic [3:0]  b_wr_addr;
  logic [7:0]  b_wr_data;
  logic        b_row_valid, b_ready, b_busy, b_stream_done, b_wr_err;
  logic [31:0] b_row_data;
  logic [1:0]  b_row_idx;

  weight_preload_buffer #(.SIZE(8), .WEIGHT_WIDTH(5), .ADDR_WIDTH(7)) dut_a (
    .clk(clk), .rst(rst), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .load_done(a_load_done), .start(a_start), .row_valid(a_row_valid),
    .row_data(a_row_data), .row_idx(a_row_idx), .ready(a_ready), .busy(a_busy),
    .stream_done(a_stream_done), .wr_err(a_wr_err)
  );

  weight_preload_buffer #(.SIZE(4), .WEIGHT_WIDTH(8)) dut_b (
    .clk(clk), .rst(rst), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .load_done(b_load_done), .start(b_start), .row_valid(b_row_valid),
    .row_data(b_row_data), .row_idx(b_row_idx), .ready(b_ready), .busy(b_busy),
    .stream_done(b_stream_done), .wr_err(b_wr_err)
  );

  int errors = 0;
  int checks = 0;

  // Reference contents: one weight per linear address
  int unsigned mem_a [64];
  int unsigned mem_b [16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] row_a(input int r);
    logic [39:0] v = '0;
    for (int c = 0; c < 8; c++) v[c*5 +: 5] = 5'(mem_a[r*8 + c]);
    return v;
  endfunction

  function automatic logic [31:0] row_b(input int r);
    logic [31:0] v = '0;
    for (int c = 0; c < 4; c++) v[c*8 +: 8] = 8'(mem_b[r*4 + c]);
    return v;
  endfunction

  // One write to instance A in IDLE/READY; out-of-range writes are dropped
  task automatic write_a(input int unsigned addr, input int unsigned data, input bit ld);
    bit err;
    err = (addr >= 64);
    a_wr_en = 1'b1; a_wr_addr = 7'(addr); a_wr_data = 5'(data); a_load_done = ld;
    @(negedge clk);
    a_wr_en = 1'b0; a_load_done = 1'b0;
    if (!err) mem_a[addr] = data;
    chk("a_wr_err", 64'(a_wr_err), 64'(err));
  endtask

  // Start a stream on A from READY and check every cycle through stream_done.
  // Optionally a write rides along with start, or a write is injected mid-stream.
  task automatic stream_a(input string tag, input bit wr_with_start, input int inject_k);
    a_start = 1'b1;
    if (wr_with_start) begin a_wr_en = 1'b1; a_wr_addr = 7'd9; a_wr_data = 5'd3; end
    @(negedge clk);
    a_start = 1'b0; a_wr_en = 1'b0;
    chk({tag, "_lead_valid"}, 64'(a_row_valid), 64'(0));
    chk({tag, "_lead_done"}, 64'(a_stream_done), 64'(0));
    chk({tag, "_lead_ready"}, 64'(a_ready), 64'(1));
    chk({tag, "_lead_wr_err"}, 64'(a_wr_err), 64'(wr_with_start));
    for (int k = 0; k < 8; k++) begin
      if (k == inject_k) begin a_wr_en = 1'b1; a_wr_addr = 7'd0; a_wr_data = 5'd31; end
      @(negedge clk);
      a_wr_en = 1'b0;
      chk({tag, "_valid"}, 64'({a_row_valid, a_busy, a_ready}), 64'(3'b110));
      chk({tag, "_idx"}, 64'(a_row_idx), 64'(7 - k));
      chk({tag, "_data"}, 64'(a_row_data), 64'(row_a(7 - k)));
      chk({tag, "_wr_err"}, 64'(a_wr_err), 64'(k == inject_k));
    end
    @(negedge clk);
    chk({tag, "_end_flags"}, 64'({a_row_valid, a_busy, a_stream_done, a_ready}), 64'(4'b0011));
    chk({tag, "_end_idx_data"}, 64'({a_row_idx, a_row_data}), 64'(0));
  endtask

  initial begin
    rst = 1'b1;
    a_wr_en = 0; a_wr_addr = '0; a_wr_data = '0; a_load_done = 0; a_start = 0;
    b_wr_en = 0; b_wr_addr = '0; b_wr_data = '0; b_load_done = 0; b_start = 0;
    for (int i = 0; i < 64; i++) mem_a[i] = 0;
    #22;
    chk("rst_a_outputs", 64'({a_row_valid, a_ready, a_busy, a_stream_done, a_wr_err, a_row_idx}), 64'(0));
    chk("rst_a_data", 64'(a_row_data), 64'(0));
    chk("rst_b_outputs", 64'({b_row_valid, b_ready, b_busy, b_stream_done, b_wr_err, b_row_idx, b_row_data}), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Start before any load is ignored
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("idle_start", 64'({a_row_valid, a_busy, a_ready}), 64'(0));
      @(negedge clk);
    end

    // Full load; the last write shares its cycle with load_done
    for (int a = 0; a < 64; a++) write_a(a, a % 32, a == 63);
    @(negedge clk);
    chk("load_ready", 64'(a_ready), 64'(1));

    stream_a("load", 1'b0, -1);
    // Back-to-back from the stream_done cycle, with a write dropped mid-stream
    stream_a("wr_in_stream", 1'b0, 2);
    stream_a("restream", 1'b0, -1);

    // Out-of-range address is dropped and must not alias into the matrix
    write_a(64, 31, 1'b0);
    write_a(127, 17, 1'b0);
    chk("oob_ready", 64'(a_ready), 64'(1));

    // In-place updates in READY, then a write colliding with start
    write_a(9, 17, 1'b0);
    for (int i = 0; i < 8; i++) write_a($urandom_range(0, 63), $urandom_range(0, 31), 1'b0);
    stream_a("wr_with_start", 1'b1, -1);

    // Reset mid-stream at row 4
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_idx", 64'(a_row_idx), 64'(4));
    rst = 1'b1;
    #1;
    chk("midrst_flags", 64'({a_row_valid, a_ready, a_busy, a_stream_done, a_wr_err, a_row_idx}), 64'(0));
    chk("midrst_data", 64'(a_row_data), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("post_rst_start", 64'({a_row_valid, a_busy, a_ready}), 64'(0));
      @(negedge clk);
    end
    a_load_done = 1'b1;
    @(negedge clk);
    a_load_done = 1'b0;
    @(negedge clk);
    chk("reload_ready", 64'(a_ready), 64'(1));
    stream_a("post_rst", 1'b0, -1);

    // Second geometry: 4x4 of 8-bit weights
    for (int a = 0; a < 16; a++) begin
      mem_b[a] = $urandom_range(0, 255);
      b_wr_en = 1'b1; b_wr_addr = 4'(a); b_wr_data = 8'(mem_b[a]); b_load_done = (a == 15);
      @(negedge clk);
    end
    b_wr_en = 1'b0; b_load_done = 1'b0;
    @(negedge clk);
    chk("b_ready", 64'(b_ready), 64'(1));
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    chk("b_lead_valid", 64'(b_row_valid), 64'(0));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("b_valid", 64'({b_row_valid, b_busy}), 64'(2'b11));
      chk("b_idx", 64'(b_row_idx), 64'(3 - k));
      chk("b_data", 64'(b_row_data), 64'(row_b(3 - k)));
    end
    @(negedge clk);
    chk("b_end", 64'({b_row_valid, b_busy, b_stream_done, b_ready}), 64'(4'b0011));
    @(negedge clk);
    chk("b_after", 64'({b_row_valid, b_stream_done, b_row_data}), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/weight_preload_buffer.md
Name: weight_preload_buffer

Overview:
Parametrised weight store for an SIZE x SIZE weight-stationary systolic array. It is written one weight per cycle by the host loader during the load phase. On command it streams the stored matrix to the array's preload chain, one full row per cycle, bottom row first. The block sits between the pre-load address generator and the systolic array's weight-shift inputs, and keeps its contents for repeated streaming.

Parameters:
SIZE, 8, array dimension (rows = columns); legal range 2..32
WEIGHT_WIDTH, 5, bits per weight
ADDR_WIDTH, $clog2(SIZE*SIZE), write-address width (6 at default)
ROW_WIDTH, $clog2(SIZE), row-counter width (3 at default)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
wr_en  input  1  write strobe for one weight
wr_addr  input  ADDR_WIDTH  linear address = row*SIZE + col
wr_data  input  WEIGHT_WIDTH  weight value
load_done  input  1  single-cycle pulse: loader finished the matrix
start  input  1  single-cycle pulse: stream matrix to array
row_valid  output  1  row_data holds a valid row this cycle
row_data  output  SIZE*WEIGHT_WIDTH  row weights; column c at bits [c*WEIGHT_WIDTH +: WEIGHT_WIDTH]
row_idx  output  ROW_WIDTH  index of the row currently on row_data
ready  output  1  matrix loaded, block idle, start will be accepted
busy  output  1  streaming in progress
stream_done  output  1  one-cycle pulse on the cycle after the last row
wr_err  output  1  one-cycle pulse: a write was dropped

Behaviour:
- Reset (async, rst=1): state=IDLE. row_valid, row_data, row_idx, ready, busy, stream_done and wr_err all = 0. Array contents are not reset and are treated as invalid until the next load_done.
- FSM states: IDLE, READY, STREAM.
  - IDLE -> READY when load_done=1.
  - READY -> STREAM when start=1.
  - STREAM -> READY after the row-0 cycle.
  - start in IDLE or STREAM is ignored.
  - load_done in READY or STREAM is ignored.
- Writes:
  - Accepted in IDLE and READY when wr_addr < SIZE*SIZE. Memory is updated at the clock edge.
  - A write in READY keeps READY; it updates the stored matrix in place.
  - wr_err pulses on the next cycle, and the write is dropped, when any of these hold: wr_en in STREAM; wr_addr >= SIZE*SIZE; wr_en and start both asserted in READY (start wins).
- Same-cycle events in IDLE: wr_en together with load_done performs the write and moves to READY; the written weight is included in the matrix.
- Streaming:
  - start accepted at edge T.
  - Edges T+1 .. T+SIZE: row_valid=1 and busy=1, with row_idx = SIZE-1, SIZE-2, ..., 0 and row_data = stored weights of that row.
  - All outputs are registered, so the first row is visible one cycle after start is sampled.
  - At edge T+SIZE+1: row_valid=0, busy=0, stream_done=1 for one cycle, ready=1.
  - row_valid is asserted for exactly SIZE consecutive cycles with no gaps.
- Outputs outside STREAM: row_data=0 and row_idx=0 whenever row_valid=0.
- ready equals (state==READY), registered.
- Row counter: counts down from SIZE-1 to 0 and does not wrap. Exit is decoded when the counter equals 0 while in STREAM.
- Restreaming: start may be issued again on the same cycle stream_done is high (state is READY). The next stream is bit-identical unless writes occurred in between.
- Reset mid-stream: outputs clear immediately and state goes to IDLE. A fresh load_done is required before start is accepted again.
- Memory organisation:
  - SIZE row registers of SIZE*WEIGHT_WIDTH bits.
  - Write decode: row = wr_addr / SIZE, col = wr_addr % SIZE. SIZE must be a power of two so these reduce to bit slices; a non-power-of-two SIZE is a parameter error flagged by an elaboration-time check.

Decomposition:
- Shared package systolic_pkg: SIZE, WEIGHT_WIDTH defaults; state enum {IDLE, READY, STREAM}; address-width and row-width localparam functions. Other array buffers reuse these.
- One natural sub-module: weight_row_bank. It holds the SIZE row registers and performs the write decode and row-select read mux. The top level holds the FSM, row counter, error logic and output registers.

Test Plan:
- Load and stream: reset, write address a with data (a % 32) for a=0..63, pulse load_done, pulse start -> 8 valid cycles, row_idx 7..0; row 7 col 0 = 24, row 0 col 7 = 7; stream_done one cycle after the last row; ready=1.
- Start before load: start in IDLE -> no row_valid and no busy for 20 cycles; ready stays 0.
- Write collisions: wr_en in STREAM at address 0 with data 31 -> wr_err pulse, a restream shows row 0 col 0 unchanged at 0. wr_addr=64 with SIZE=8 -> dropped with wr_err. wr_en and start in the same READY cycle -> stream starts, wr_err=1.
- In-place update and back-to-back: in READY write address 9 = 17, start -> row 1 col 1 = 17. Start again on the stream_done cycle -> second burst immediately follows with no gap beyond the stream_done cycle.
- Reset mid-stream: assert rst at row_idx=4 -> all outputs 0 the same cycle. After release, start is ignored until load_done, and the contents written before reset still stream correctly.
- Parameter sweep: SIZE=4, WEIGHT_WIDTH=8, full load, stream -> exactly 4 valid cycles with 32-bit rows matching the written data.
